// File: rtl/mem_dual_port.sv
// Dual-port storage with registered read, write-first bypass and fill tracking.
// Define MEM_DUAL_PORT_OUT_REG_EN to add a second output register stage.
module mem_dual_port #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  rd_unwritten,
  output logic [ADDR_WIDTH:0]   fill_count
);

  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      written;

  logic wr_in;
  logic rd_in;
  logic wr_ok;
  logic hit;

  assign wr_in = {1'b0, wr_address} < LIMIT;
  assign rd_in = {1'b0, rd_address} < LIMIT;
  assign wr_ok = write && wr_in && !clear;
  assign hit   = wr_ok && read && (wr_address == rd_address);

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      written    <= '0;
      fill_count <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      written    <= '0;
      fill_count <= '0;
    end else if (wr_ok) begin
      mem[wr_address]     <= data_in;
      written[wr_address] <= 1'b1;
      if (!written[wr_address]) fill_count <= fill_count + ONE;
    end
  end

  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_unw;

  // Out-of-range reads fall through to the zero/unwritten default.
  always_comb begin
    rd_data = '0;
    rd_unw  = 1'b1;
    unique case (1'b1)
      hit: begin
        rd_data = data_in;
        rd_unw  = 1'b0;
      end
      (rd_in && !hit): begin
        rd_data = mem[rd_address];
        rd_unw  = ~written[rd_address];
      end
      default: ;
    endcase
  end

  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid;
  logic                  s1_unw;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_unw   <= 1'b0;
    end else if (read) begin
      s1_data  <= rd_data;
      s1_valid <= 1'b1;
      s1_unw   <= rd_unw;
    end else begin
      s1_valid <= 1'b0;
      s1_unw   <= 1'b0;
    end
  end

`ifdef MEM_DUAL_PORT_OUT_REG_EN
  logic [DATA_WIDTH-1:0] s2_data;
  logic                  s2_valid;
  logic                  s2_unw;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      s2_data  <= '0;
      s2_valid <= 1'b0;
      s2_unw   <= 1'b0;
    end else begin
      s2_data  <= s1_data;
      s2_valid <= s1_valid;
      s2_unw   <= s1_unw;
    end
  end

  assign data_out     = s2_data;
  assign valid_out    = s2_valid;
  assign rd_unwritten = s2_unw;
`else
  assign data_out     = s1_data;
  assign valid_out    = s1_valid;
  assign rd_unwritten = s1_unw;
`endif

endmodule

// File: tb/tb_mem_dual_port.sv
// Bench for mem_dual_port: DEPTH=8 and DEPTH=6 instances share stimulus.
// A spec-level model predicts every output of both instances.
module tb_mem_dual_port;

`ifdef MEM_DUAL_PORT_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       write;
  logic [2:0] wr_address;
  logic [5:0] data_in;
  logic       read;
  logic [2:0] rd_address;
  logic       clear;

  logic [5:0] dout8, dout6;
  logic       v8, v6, u8, u6;
  logic [3:0] fc8, fc6;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_dual_port #(.DATA_WIDTH(6), .ADDR_WIDTH(3), .DEPTH(8)) dut8 (
    .clk(clk), .RESET(rst), .write(write), .wr_address(wr_address),
    .data_in(data_in), .read(read), .rd_address(rd_address),
    .clear(clear), .data_out(dout8), .valid_out(v8),
    .rd_unwritten(u8), .fill_count(fc8)
  );

  mem_dual_port #(.DATA_WIDTH(6), .ADDR_WIDTH(3), .DEPTH(6)) dut6 (
    .clk(clk), .RESET(rst), .write(write), .wr_address(wr_address),
    .data_in(data_in), .read(read), .rd_address(rd_address),
    .clear(clear), .data_out(dout6), .valid_out(v6),
    .rd_unwritten(u6), .fill_count(fc6)
  );

  int depth [2] = '{8, 6};
  int m_mem [2][8];
  bit m_wr  [2][8];
  int p_d   [2][2];
  bit p_v   [2][2];
  bit p_u   [2][2];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_fill(input int k);
    int n = 0;
    for (int i = 0; i < depth[k]; i++) n += int'(m_wr[k][i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        m_mem[k][i] = 0;
        m_wr[k][i]  = 1'b0;
      end
      for (int s = 0; s < 2; s++) begin
        p_d[k][s] = 0;
        p_v[k][s] = 1'b0;
        p_u[k][s] = 1'b0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "/d8"}, 32'(dout8), 32'(p_d[0][LAT-1]));
    check({tag, "/v8"}, 32'(v8), 32'(p_v[0][LAT-1]));
    check({tag, "/u8"}, 32'(u8), 32'(p_u[0][LAT-1]));
    check({tag, "/f8"}, 32'(fc8), 32'(model_fill(0)));
    check({tag, "/d6"}, 32'(dout6), 32'(p_d[1][LAT-1]));
    check({tag, "/v6"}, 32'(v6), 32'(p_v[1][LAT-1]));
    check({tag, "/u6"}, 32'(u6), 32'(p_u[1][LAT-1]));
    check({tag, "/f6"}, 32'(fc6), 32'(model_fill(1)));
  endtask

  // One clock: drive, predict from pre-edge model, clock, compare.
  task automatic step(input string tag, input bit w, input int wa,
                      input int wd, input bit r, input int ra, input bit c);
    int  nd [2];
    bit  nv [2];
    bit  nu [2];
    bit  ok [2];
    write      = w;
    wr_address = 3'(wa);
    data_in    = 6'(wd);
    read       = r;
    rd_address = 3'(ra);
    clear      = c;
    for (int k = 0; k < 2; k++) begin
      ok[k] = w && !c && (wa < depth[k]);
      if (!r) begin
        nd[k] = p_d[k][0];
        nv[k] = 1'b0;
        nu[k] = 1'b0;
      end else if (ok[k] && ra == wa) begin
        nd[k] = wd;
        nv[k] = 1'b1;
        nu[k] = 1'b0;
      end else if (ra < depth[k]) begin
        nd[k] = m_mem[k][ra];
        nv[k] = 1'b1;
        nu[k] = !m_wr[k][ra];
      end else begin
        nd[k] = 0;
        nv[k] = 1'b1;
        nu[k] = 1'b1;
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (c) begin
        for (int i = 0; i < 8; i++) begin
          m_mem[k][i] = 0;
          m_wr[k][i]  = 1'b0;
        end
      end else if (ok[k]) begin
        m_mem[k][wa] = wd;
        m_wr[k][wa]  = 1'b1;
      end
      p_d[k][1] = p_d[k][0];
      p_v[k][1] = p_v[k][0];
      p_u[k][1] = p_u[k][0];
      p_d[k][0] = nd[k];
      p_v[k][0] = nv[k];
      p_u[k][0] = nu[k];
    end
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 0, 0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    write = 1'b0; wr_address = '0; data_in = '0;
    read = 1'b0;  rd_address = '0; clear = 1'b0;
    model_reset();
    #3;
    compare_all("reset");
    #10;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) step("fill", 1'b1, i, i + 1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++) step("rdback", 1'b0, 0, 0, 1'b1, i, 1'b0);
    for (int i = 0; i < LAT; i++) idle("drain");

    step("collide", 1'b1, 3, 6'h2A, 1'b1, 3, 1'b0);
    step("reread", 1'b0, 0, 0, 1'b1, 3, 1'b0);
    step("indep", 1'b1, 1, 6'h11, 1'b1, 2, 1'b0);
    for (int i = 0; i < LAT; i++) idle("drain");

    step("clr", 1'b1, 0, 6'h3F, 1'b1, 0, 1'b1);
    step("clr_rd", 1'b0, 0, 0, 1'b1, 0, 1'b0);
    for (int i = 0; i < LAT; i++) idle("drain");

    step("ovw1", 1'b1, 3, 6'hB, 1'b0, 0, 1'b0);
    step("ovw2", 1'b1, 3, 6'hB, 1'b0, 0, 1'b0);
    step("unw", 1'b0, 0, 0, 1'b1, 5, 1'b0);
    step("oor_wr", 1'b1, 7, 6'h15, 1'b0, 0, 1'b0);
    step("oor_rd", 1'b0, 0, 0, 1'b1, 7, 1'b0);
    step("oor_6", 1'b1, 6, 6'h09, 1'b1, 6, 1'b0);
    for (int i = 0; i < LAT; i++) idle("drain");

    for (int n = 0; n < 400; n++) begin
      int wa;
      int ra;
      wa = int'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 7));
      step("rand", 1'($urandom_range(0, 1)), wa,
           int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), ra,
           $urandom_range(0, 31) == 0);
    end

    for (int i = 0; i < 8; i++) step("refill", 1'b1, i, i + 9, 1'b0, 0, 1'b0);
    for (int i = 1; i < 6; i++) step("burst", 1'b0, 0, 0, 1'b1, i, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("arst/d8", 32'(dout8), 32'd0);
    check("arst/v8", 32'(v8), 32'd0);
    check("arst/u8", 32'(u8), 32'd0);
    check("arst/f8", 32'(fc8), 32'd0);
    check("arst/d6", 32'(dout6), 32'd0);
    check("arst/v6", 32'(v6), 32'd0);
    check("arst/f6", 32'(fc6), 32'd0);
    #1;
    rst = 1'b0;
    model_reset();
    step("post_rst", 1'b0, 0, 0, 1'b1, 0, 1'b0);
    for (int i = 0; i < LAT; i++) idle("drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
